// File: rtl/slc3_button_conditioner.sv
// SLC-3 key front end: sync + debounce of the Run/Continue keys, press pulses,
// and a held-chord soft reset request.

module slc3_key_debounce #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic Clk,
    input  logic Reset,
    input  logic key_n_i,
    output logic level_o,
    output logic level_d_o
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [1:0]    sync_q;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          level_q, level_d;
    logic          s;

    assign s = ~sync_q[1];

    // Any sample matching the current level restarts the count.
    always_comb begin
        level_d = level_q;
        cnt_d   = cnt_q;
        if (s == level_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
            level_d = s;
            cnt_d   = '0;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            sync_q  <= 2'b11;
            cnt_q   <= '0;
            level_q <= 1'b0;
        end else begin
            sync_q  <= {sync_q[0], key_n_i};
            cnt_q   <= cnt_d;
            level_q <= level_d;
        end
    end

    assign level_o   = level_q;
    assign level_d_o = level_d;
endmodule

module slc3_button_conditioner #(
    parameter int DEBOUNCE_CYCLES   = 16,
    parameter int RESET_HOLD_CYCLES = 8
) (
    input  logic Clk,
    input  logic Reset,
    input  logic Run_n,
    input  logic Continue_n,
    output logic Run_level,
    output logic Continue_level,
    output logic Run_pulse,
    output logic Continue_pulse,
    output logic Soft_reset
);
    localparam int HW = (RESET_HOLD_CYCLES > 1) ? $clog2(RESET_HOLD_CYCLES) : 1;
    localparam logic [HW-1:0] HOLD_LAST = HW'(RESET_HOLD_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        CHORD,
        SRESET
    } state_t;

    state_t        state_q;
    logic [HW-1:0] hold_q;
    logic          soft_q;
    logic          run_pulse_q, run_pulse_d;
    logic          cont_pulse_q, cont_pulse_d;
    logic          run_lvl_q, run_lvl_d;
    logic          cont_lvl_q, cont_lvl_d;

    slc3_key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_run (
        .Clk      (Clk),
        .Reset    (Reset),
        .key_n_i  (Run_n),
        .level_o  (run_lvl_q),
        .level_d_o(run_lvl_d)
    );

    slc3_key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_cont (
        .Clk      (Clk),
        .Reset    (Reset),
        .key_n_i  (Continue_n),
        .level_o  (cont_lvl_q),
        .level_d_o(cont_lvl_d)
    );

    // Decisions use next-cycle levels so a simultaneous rise is seen as a chord.
    always_comb begin
        run_pulse_d  = run_lvl_d & ~run_lvl_q & ~cont_lvl_d & (state_q == IDLE);
        cont_pulse_d = cont_lvl_d & ~cont_lvl_q & ~run_lvl_d & (state_q == IDLE);
    end

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            run_pulse_q  <= 1'b0;
            cont_pulse_q <= 1'b0;
        end else begin
            run_pulse_q  <= run_pulse_d;
            cont_pulse_q <= cont_pulse_d;
        end
    end

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            state_q <= IDLE;
            hold_q  <= '0;
            soft_q  <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (run_lvl_d && cont_lvl_d) begin
                        state_q <= CHORD;
                        hold_q  <= '0;
                    end
                end
                CHORD: begin
                    if (!(run_lvl_d && cont_lvl_d)) begin
                        state_q <= IDLE;
                    end else if (hold_q == HOLD_LAST) begin
                        state_q <= SRESET;
                        soft_q  <= 1'b1;
                    end else begin
                        hold_q <= hold_q + HW'(1);
                    end
                end
                SRESET: begin
                    if (!run_lvl_d && !cont_lvl_d) begin
                        state_q <= IDLE;
                        soft_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    soft_q  <= 1'b0;
                end
            endcase
        end
    end

    assign Run_level      = run_lvl_q;
    assign Continue_level = cont_lvl_q;
    assign Run_pulse      = run_pulse_q;
    assign Continue_pulse = cont_pulse_q;
    assign Soft_reset     = soft_q;
endmodule

// File: tb/tb_slc3_button_conditioner.sv
// Directed bench for slc3_button_conditioner with DEBOUNCE_CYCLES=4,
// RESET_HOLD_CYCLES=3; press-to-level latency is 5 edges.

module tb_slc3_button_conditioner;
    logic Clk = 1'b0;
    logic Reset;
    logic Run_n;
    logic Continue_n;
    logic Run_level;
    logic Continue_level;
    logic Run_pulse;
    logic Continue_pulse;
    logic Soft_reset;

    int n_vec = 0;
    int n_err = 0;
    int run_pc = 0;
    int cont_pc = 0;
    int rp0;
    int cp0;

    slc3_button_conditioner #(
        .DEBOUNCE_CYCLES  (4),
        .RESET_HOLD_CYCLES(3)
    ) dut (
        .Clk           (Clk),
        .Reset         (Reset),
        .Run_n         (Run_n),
        .Continue_n    (Continue_n),
        .Run_level     (Run_level),
        .Continue_level(Continue_level),
        .Run_pulse     (Run_pulse),
        .Continue_pulse(Continue_pulse),
        .Soft_reset    (Soft_reset)
    );

    always #5 Clk = ~Clk;

    // Pulse cycles counted away from the active edge.
    always @(negedge Clk) begin
        if (Run_pulse === 1'b1) run_pc++;
        if (Continue_pulse === 1'b1) cont_pc++;
    end

    task automatic step(input int n);
        repeat (n) @(posedge Clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    initial begin
        Reset = 1'b0;
        Run_n = 1'b1;
        Continue_n = 1'b1;
        step(2);
        chk("rst_run_level", 32'(Run_level), 0);
        chk("rst_cont_level", 32'(Continue_level), 0);
        chk("rst_run_pulse", 32'(Run_pulse), 0);
        chk("rst_cont_pulse", 32'(Continue_pulse), 0);
        chk("rst_soft", 32'(Soft_reset), 0);
        Reset = 1'b1;

        // 1: clean Run press sampled at edge 2, release sampled at edge 22
        step(2);
        rp0 = run_pc;
        cp0 = cont_pc;
        Run_n = 1'b0;
        step(5);
        chk("t1_level_e6", 32'(Run_level), 0);
        step(1);
        chk("t1_level_e7", 32'(Run_level), 1);
        chk("t1_pulse_e7", 32'(Run_pulse), 1);
        step(1);
        chk("t1_pulse_e8", 32'(Run_pulse), 0);
        step(13);
        Run_n = 1'b1;
        step(5);
        chk("t1_rel_e26", 32'(Run_level), 1);
        step(1);
        chk("t1_rel_e27", 32'(Run_level), 0);
        chk("t1_pulse_count", 32'(run_pc - rp0), 1);
        chk("t1_cont_level", 32'(Continue_level), 0);
        chk("t1_cont_pulses", 32'(cont_pc - cp0), 0);

        // 2: bouncing Continue never reaches 4 stable samples
        cp0 = cont_pc;
        for (int i = 0; i < 5; i++) begin
            Continue_n = 1'b0;
            step(3);
            Continue_n = 1'b1;
            step(1);
            chk("t2_bounce_level", 32'(Continue_level), 0);
        end
        step(6);
        chk("t2_final_level", 32'(Continue_level), 0);
        chk("t2_pulses", 32'(cont_pc - cp0), 0);

        // 3: both keys together -> chord -> soft reset
        rp0 = run_pc;
        cp0 = cont_pc;
        Run_n = 1'b0;
        Continue_n = 1'b0;
        step(6);
        chk("t3_run_level", 32'(Run_level), 1);
        chk("t3_cont_level", 32'(Continue_level), 1);
        step(2);
        chk("t3_soft_e9", 32'(Soft_reset), 0);
        step(1);
        chk("t3_soft_e10", 32'(Soft_reset), 1);
        chk("t3_no_pulses", 32'((run_pc - rp0) + (cont_pc - cp0)), 0);
        Run_n = 1'b1;
        step(6);
        chk("t3_run_released", 32'(Run_level), 0);
        chk("t3_soft_hold1", 32'(Soft_reset), 1);
        Run_n = 1'b0;
        step(6);
        chk("t3_run_repress", 32'(Run_level), 1);
        chk("t3_soft_hold2", 32'(Soft_reset), 1);
        chk("t3_repress_pulse", 32'(run_pc - rp0), 0);
        Run_n = 1'b1;
        Continue_n = 1'b1;
        step(5);
        chk("t3_cont_still", 32'(Continue_level), 1);
        chk("t3_soft_still", 32'(Soft_reset), 1);
        step(1);
        chk("t3_cont_fell", 32'(Continue_level), 0);
        chk("t3_soft_clear", 32'(Soft_reset), 0);

        // 4: short chord; Continue first, Run joins as Continue leaves
        rp0 = run_pc;
        cp0 = cont_pc;
        Continue_n = 1'b0;
        step(3);
        Run_n = 1'b0;
        step(1);
        Continue_n = 1'b1;
        step(2);
        chk("t4_cont_up", 32'(Continue_level), 1);
        chk("t4_cont_pulse", 32'(Continue_pulse), 1);
        step(3);
        chk("t4_both_run", 32'(Run_level), 1);
        chk("t4_both_cont", 32'(Continue_level), 1);
        step(1);
        chk("t4_cont_down", 32'(Continue_level), 0);
        step(3);
        chk("t4_no_soft", 32'(Soft_reset), 0);
        Run_n = 1'b1;
        step(6);
        chk("t4_run_down", 32'(Run_level), 0);
        chk("t4_run_pulses", 32'(run_pc - rp0), 0);
        chk("t4_cont_pulses1", 32'(cont_pc - cp0), 1);
        Continue_n = 1'b0;
        step(5);
        chk("t4_repress_early", 32'(Continue_level), 0);
        step(1);
        chk("t4_repress_level", 32'(Continue_level), 1);
        chk("t4_repress_pulse", 32'(Continue_pulse), 1);
        step(1);
        chk("t4_repress_pulse_end", 32'(Continue_pulse), 0);
        Continue_n = 1'b1;
        step(6);
        chk("t4_cont_pulses2", 32'(cont_pc - cp0), 2);
        chk("t4_soft_never", 32'(Soft_reset), 0);

        // 5: reset while in soft reset with both keys held
        Run_n = 1'b0;
        Continue_n = 1'b0;
        step(9);
        chk("t5_soft_before", 32'(Soft_reset), 1);
        rp0 = run_pc;
        cp0 = cont_pc;
        Reset = 1'b0;
        step(1);
        Reset = 1'b1;
        chk("t5_rst_run_level", 32'(Run_level), 0);
        chk("t5_rst_cont_level", 32'(Continue_level), 0);
        chk("t5_rst_soft", 32'(Soft_reset), 0);
        step(5);
        chk("t5_levels_early", 32'({Run_level, Continue_level}), 0);
        step(1);
        chk("t5_levels_back", 32'({Run_level, Continue_level}), 3);
        step(2);
        chk("t5_soft_early", 32'(Soft_reset), 0);
        step(1);
        chk("t5_soft_again", 32'(Soft_reset), 1);
        chk("t5_no_pulses", 32'((run_pc - rp0) + (cont_pc - cp0)), 0);
        Run_n = 1'b1;
        Continue_n = 1'b1;
        step(6);
        chk("t5_release_soft", 32'(Soft_reset), 0);

        // 6: staggered press; Run first, then Continue
        rp0 = run_pc;
        cp0 = cont_pc;
        Run_n = 1'b0;
        step(6);
        chk("t6_run_level", 32'(Run_level), 1);
        chk("t6_run_pulse", 32'(Run_pulse), 1);
        Continue_n = 1'b0;
        step(5);
        chk("t6_cont_early", 32'(Continue_level), 0);
        step(1);
        chk("t6_cont_level", 32'(Continue_level), 1);
        step(2);
        chk("t6_soft_early", 32'(Soft_reset), 0);
        step(1);
        chk("t6_soft", 32'(Soft_reset), 1);
        chk("t6_run_pulses", 32'(run_pc - rp0), 1);
        chk("t6_cont_pulses", 32'(cont_pc - cp0), 0);
        Run_n = 1'b1;
        Continue_n = 1'b1;
        step(6);
        chk("t6_final_soft", 32'(Soft_reset), 0);
        chk("t6_final_levels", 32'({Run_level, Continue_level}), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
